// File: rtl/cassette_recorder.sv
// FSK cassette capture: demodulates the 6-bit DAC waveform into bytes and
// streams them through a small FIFO into sequential SDRAM writes.
module cassette_recorder #(
  parameter int MID        = 32,
  parameter int HYST       = 2,
  parameter int THRESH     = 560,
  parameter int MIN_PERIOD = 150,
  parameter int GAP        = 2047,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Q,
  input  logic        en,
  input  logic        rewind,
  input  logic [5:0]  dac,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_data,
  output logic        sdram_wr,
  input  logic        sdram_ack,
  output logic [24:0] length,
  output logic        overflow,
  output logic        recording
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [6:0]  HI_TH = 7'(MID + HYST);
  localparam logic [6:0]  LO_TH = 7'(MID - HYST);
  localparam logic [10:0] GAP_C = 11'(GAP);
  localparam logic [10:0] THR_C = 11'(THRESH);
  localparam logic [10:0] MIN_C = 11'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t      state;
  logic        q_d1, q_d2, tick;
  logic        hi, hi_nxt, rise, seen;
  logic [10:0] cnt;
  logic [2:0]  bcnt;
  logic [7:0]  sr, sr_nxt;
  logic        push_vld;
  logic [7:0]  push_byte;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] occ;
  logic          pop, push_ok;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign tick   = q_d1 & ~q_d2;
  assign hi_nxt = ({1'b0, dac} >= HI_TH) ? 1'b1 :
                  ({1'b0, dac} <= LO_TH) ? 1'b0 : hi;
  assign rise   = tick & ~hi & hi_nxt;
  // Bits arrive LSB first, so each new bit enters at the top and shifts down.
  assign sr_nxt = {(cnt < THR_C), sr[7:1]};
  assign recording = seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_d1 <= 1'b0; q_d2 <= 1'b0; hi <= 1'b0; seen <= 1'b0;
      state <= IDLE; cnt <= '0; bcnt <= '0; sr <= '0;
      push_vld <= 1'b0; push_byte <= '0;
    end else begin
      q_d1 <= Q;
      q_d2 <= q_d1;
      push_vld <= 1'b0;
      if (tick) hi <= hi_nxt;
      if (!en) seen <= 1'b0;
      else if (rise && state != IDLE) seen <= 1'b1;
      if (rewind) begin
        state <= en ? SYNC : IDLE;
        cnt <= '0; bcnt <= '0; sr <= '0;
      end else if (!en) begin
        state <= IDLE;
        cnt <= '0; bcnt <= '0; sr <= '0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: if (tick) begin
            if (rise) begin
              cnt   <= '0;
              state <= RUN;
            end else if (cnt != GAP_C) cnt <= cnt + 11'd1;
          end
          RUN: if (cnt == GAP_C) begin
            state <= SYNC;
            bcnt  <= '0;
            sr    <= '0;
          end else if (tick) begin
            if (rise && cnt >= MIN_C) begin
              cnt <= '0;
              sr  <= sr_nxt;
              if (bcnt == 3'd7) begin
                bcnt      <= '0;
                push_vld  <= 1'b1;
                push_byte <= sr_nxt;
              end else bcnt <= bcnt + 3'd1;
            end else cnt <= cnt + 11'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pop     = sdram_wr & sdram_ack;
  assign push_ok = push_vld & ((occ != CW'(FIFO_DEPTH)) | pop);

  always_ff @(posedge clk)
    if (push_ok && !rewind) mem[wp] <= push_byte;

  // sdram_addr doubles as the tape write pointer; it only moves on ack, which
  // also drops sdram_wr, so address and data stay put for a pending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0; rp <= '0; occ <= '0;
      sdram_wr <= 1'b0; sdram_addr <= '0; sdram_data <= '0;
      length <= '0; overflow <= 1'b0;
    end else if (rewind) begin
      wp <= '0; rp <= '0; occ <= '0;
      sdram_wr <= 1'b0; sdram_addr <= '0;
      length <= '0; overflow <= 1'b0;
    end else begin
      if (push_ok) wp <= inc(wp);
      else if (push_vld) overflow <= 1'b1;
      if (pop) begin
        rp         <= inc(rp);
        sdram_addr <= sdram_addr + 25'd1;
        length     <= length + 25'd1;
        sdram_wr   <= 1'b0;
      end else if (!sdram_wr && occ != '0) begin
        sdram_wr   <= 1'b1;
        sdram_data <= mem[rp];
      end
      occ <= occ + CW'(push_ok) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_cassette_recorder.sv
// Scoreboard bench for cassette_recorder: synthesizes FSK square waves on dac,
// queues expected SDRAM writes and checks them as the acknowledger accepts them.
module tb_cassette_recorder;
  // Timing parameters scaled by 1/4 so the whole run stays short.
  localparam int T1 = 93, T0 = 187, IDLE_T = 530;

  logic        clk = 0, reset = 0, Q = 0, en = 0, rewind = 0, sdram_ack = 0;
  logic [5:0]  dac = 6'd20;
  logic [24:0] sdram_addr, length;
  logic [7:0]  sdram_data;
  logic        sdram_wr, overflow, recording;

  typedef struct packed {logic [24:0] a; logic [7:0] d;} wr_t;
  wr_t         exp_q[$];
  wr_t         e;
  int          n_chk = 0, n_err = 0;
  logic        ack_en = 1;
  logic [24:0] addr_m = 0;

  cassette_recorder #(.THRESH(140), .MIN_PERIOD(38), .GAP(511)) dut (
    .clk(clk), .reset(reset), .Q(Q), .en(en), .rewind(rewind), .dac(dac),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_wr(sdram_wr),
    .sdram_ack(sdram_ack), .length(length), .overflow(overflow),
    .recording(recording)
  );

  always #5 clk = ~clk;
  always #10 Q = ~Q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acknowledger: accepts a pending write on the negedge and pops the scoreboard.
  always @(negedge clk) begin
    if (reset && ack_en && sdram_wr && !sdram_ack) begin
      sdram_ack = 1'b1;
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(sdram_addr), 32'(e.a));
        chk("wr_data", 32'(sdram_data), 32'(e.d));
      end
    end else sdram_ack = 1'b0;
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge Q);
  endtask

  // One bit period, rising edge to rising edge; ends with dac high.
  task automatic bitc(input bit b, input bit noise = 0);
    int n = b ? T1 : T0;
    if (noise) begin
      ticks(20); dac = 6'd20; ticks(5); dac = 6'd44; ticks(n/2 - 25);
    end else ticks(n/2);
    dac = 6'd20;
    ticks(n - n/2);
    dac = 6'd44;
  endtask

  task automatic sync_edge();
    dac = 6'd20; ticks(T1); dac = 6'd44;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_wr = 1, input int noise_bit = -1);
    if (expect_wr) begin
      exp_q.push_back('{a: addr_m, d: b});
      addr_m++;
    end
    for (int i = 0; i < 8; i++) bitc(b[i], i == noise_bit);
  endtask

  task automatic idle();
    ticks(T1/2); dac = 6'd20; ticks(IDLE_T);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk); k++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 0; dac = 6'd20; ack_en = 1; rewind = 0;
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    addr_m = 0;
    repeat (2) @(negedge clk);
    chk("rst_wr",   32'(sdram_wr),   32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_data", 32'(sdram_data), 32'd0);
    chk("rst_len",  32'(length),     32'd0);
    chk("rst_ovf",  32'(overflow),   32'd0);
    chk("rst_rec",  32'(recording),  32'd0);
    reset = 1;
    @(negedge clk);
    en = 1;
  endtask

  initial begin
    int k;
    // Single byte decode
    do_reset();
    ticks(5);
    chk("rec_before_sync", 32'(recording), 32'd0);
    sync_edge(); ticks(3);
    chk("rec_after_sync", 32'(recording), 32'd1);
    send_byte(8'h55); idle(); drain("b55");
    chk("len_b55", 32'(length), 32'd1);

    // Stream
    do_reset(); sync_edge();
    send_byte(8'h3C); send_byte(8'h00); send_byte(8'hFF);
    idle(); drain("stream");
    chk("len_stream", 32'(length), 32'd3);

    // Gap realign: partial byte is thrown away
    do_reset(); sync_edge();
    bitc(1); bitc(0); bitc(1); bitc(1); bitc(0);
    ticks(525);
    sync_edge(); send_byte(8'hA5); idle(); drain("gap");
    chk("len_gap", 32'(length), 32'd1);

    // Overflow: FIFO holds 4, the 5th byte is dropped
    do_reset(); ack_en = 0; sync_edge();
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    repeat (10) @(negedge clk);
    chk("ovf_before", 32'(overflow), 32'd0);
    send_byte(8'h05, 0);
    repeat (10) @(negedge clk);
    chk("ovf_after", 32'(overflow), 32'd1);
    chk("ovf_wr_held", 32'(sdram_wr), 32'd1);
    chk("ovf_addr_held", 32'(sdram_addr), 32'd0);
    chk("ovf_data_held", 32'(sdram_data), 32'h01);
    ack_en = 1; idle(); drain("ovf");
    chk("len_ovf", 32'(length), 32'd4);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Noise crossing inside a 0 bit
    do_reset(); sync_edge();
    send_byte(8'h5A, 1, 0); idle(); drain("noise");
    chk("len_noise", 32'(length), 32'd1);

    // Relay drop mid-byte, then rewind
    do_reset(); sync_edge();
    bitc(1); bitc(0); bitc(1);
    en = 0; ticks(3);
    chk("rec_en_low", 32'(recording), 32'd0);
    dac = 6'd20; ticks(20); en = 1;
    sync_edge(); send_byte(8'h12); idle(); drain("relay");
    chk("len_relay", 32'(length), 32'd1);
    @(negedge clk); rewind = 1;
    @(negedge clk); rewind = 0; addr_m = 0;
    chk("rew_len",  32'(length),     32'd0);
    chk("rew_ovf",  32'(overflow),   32'd0);
    chk("rew_addr", 32'(sdram_addr), 32'd0);
    sync_edge(); send_byte(8'h7E); idle(); drain("rewind");
    chk("len_rewind", 32'(length), 32'd1);

    // Reset during a pending write drops sdram_wr without a clock edge
    do_reset(); ack_en = 0; sync_edge();
    send_byte(8'hC3, 0);
    k = 0;
    while (!sdram_wr && k < 50) begin
      @(negedge clk); k++;
    end
    chk("wr_pending", 32'(sdram_wr), 32'd1);
    #2 reset = 0;
    #1 chk("wr_async_rst", 32'(sdram_wr), 32'd0);
    reset = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
